// File: rtl/ex_mdu_pkg.sv
// Shared constants and types for the ex_mdu execute stage: RV32IM opcode/funct fields,
// the canonical NOP, divider FSM state encoding and divide special-case results.
package ex_mdu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;

  localparam logic [6:0]  F7_MULDIV = 7'b0000001;
  localparam logic [31:0] INST_NOP  = 32'h00000013;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFFFFFF;
  localparam logic [31:0] OVF_QUOT  = 32'h80000000;
  localparam logic [31:0] OVF_REM   = 32'h00000000;
  localparam logic [31:0] INT_MIN   = 32'h80000000;
  localparam logic [31:0] NEG_ONE   = 32'hFFFFFFFF;

endpackage

// File: rtl/ex_mdu_div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: IDLE/BUSY/DONE FSM, magnitude
// datapath retiring BITS quotient bits per BUSY cycle, and sign fix-up of the result.
module ex_mdu_div_unit
  import ex_mdu_pkg::*;
#(
  parameter int BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  // start_i is a level request honoured only in IDLE; done_o pulses for exactly one
  // cycle and result_o/rd_addr_o/wen_o are valid only while it is high.
  input  logic        start_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        signed_i,
  input  logic        rem_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        wen_i,
  output logic        busy_o,
  output logic        done_o,
  output div_state_e  state_o,
  output logic [31:0] result_o,
  output logic [4:0]  rd_addr_o,
  output logic        wen_o
);

  localparam logic [5:0] STEPS = 6'(32 / BITS);

  div_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, quot_q, quot_d, dvs_q, dvs_d;
  logic        neg_quot_q, neg_quot_d, neg_rem_q, neg_rem_d, is_rem_q, is_rem_d;
  logic [4:0]  rd_q, rd_d;
  logic        wen_q, wen_d;

  logic        a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  logic [32:0] trial;
  logic [31:0] r_step, q_step;

  assign a_neg = signed_i & dividend_i[31];
  assign b_neg = signed_i & divisor_i[31];
  assign mag_a = a_neg ? -dividend_i : dividend_i;
  assign mag_b = b_neg ? -divisor_i : divisor_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvs_d      = dvs_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    is_rem_d   = is_rem_q;
    rd_d       = rd_q;
    wen_d      = wen_q;
    trial      = '0;
    r_step     = rem_q;
    q_step     = quot_q;
    case (state_q)
      DIV_IDLE: begin
        if (start_i) begin
          is_rem_d = rem_i;
          rd_d     = rd_addr_i;
          wen_d    = wen_i;
          dvs_d    = mag_b;
          state_d  = DIV_DONE;
          // Special cases park their final value unsigned so the DONE fix-up is a no-op.
          if (divisor_i == '0) begin
            quot_d     = DIV0_QUOT;
            rem_d      = dividend_i;
            neg_quot_d = 1'b0;
            neg_rem_d  = 1'b0;
          end else if (signed_i && dividend_i == INT_MIN && divisor_i == NEG_ONE) begin
            quot_d     = OVF_QUOT;
            rem_d      = OVF_REM;
            neg_quot_d = 1'b0;
            neg_rem_d  = 1'b0;
          end else begin
            quot_d     = mag_a;
            rem_d      = '0;
            neg_quot_d = a_neg ^ b_neg;
            neg_rem_d  = a_neg;
            cnt_d      = STEPS;
            state_d    = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        for (int k = 0; k < BITS; k++) begin
          trial  = {r_step, q_step[31]};
          q_step = {q_step[30:0], 1'b0};
          if (trial >= {1'b0, dvs_q}) begin
            trial     = trial - {1'b0, dvs_q};
            q_step[0] = 1'b1;
          end
          r_step = trial[31:0];
        end
        rem_d  = r_step;
        quot_d = q_step;
        cnt_d  = cnt_q - 6'd1;
        if (cnt_d == '0) state_d = DIV_DONE;
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvs_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      is_rem_q   <= 1'b0;
      rd_q       <= '0;
      wen_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvs_q      <= dvs_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      is_rem_q   <= is_rem_d;
      rd_q       <= rd_d;
      wen_q      <= wen_d;
    end
  end

  assign busy_o    = (state_q == DIV_BUSY);
  assign done_o    = (state_q == DIV_DONE);
  assign state_o   = state_q;
  assign rd_addr_o = rd_q;
  assign wen_o     = wen_q;
  assign result_o  = is_rem_q ? (neg_rem_q ? -rem_q : rem_q)
                              : (neg_quot_q ? -quot_q : quot_q);

endmodule

// File: rtl/ex_mdu.sv
// RV32 execute stage: single-cycle ALU, branch/jump resolution, output muxing and the
// divider hold. Define EX_MUL_EN to add single-cycle MUL/MULH/MULHSU/MULHU.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        reg_wen_i,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        rd_wen_o,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        hold_o
);

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_b, imm_j, imm_u;
  logic        is_muldiv, is_div, div_start;
  logic [31:0] alu_res;
  logic        br_taken;

  logic        div_busy, div_done, div_wen;
  div_state_e  div_state;
  logic [31:0] div_res;
  logic [4:0]  div_rd;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_b  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_j  = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign imm_u  = {inst_i[31:12], 12'b0};

  assign is_muldiv = (opcode == OPC_OP) && (funct7 == F7_MULDIV);
  assign is_div    = is_muldiv && funct3[2];
  // Only IDLE accepts, so the divide still visible on inst_i during DONE cannot restart.
  assign div_start = rst && is_div && (div_state == DIV_IDLE);

  ex_mdu_div_unit #(.BITS(DIV_BITS_PER_CYCLE)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .dividend_i (op1_i),
    .divisor_i  (op2_i),
    .signed_i   (~funct3[0]),
    .rem_i      (funct3[1]),
    .rd_addr_i  (rd_addr_i),
    .wen_i      (reg_wen_i),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .state_o    (div_state),
    .result_o   (div_res),
    .rd_addr_o  (div_rd),
    .wen_o      (div_wen)
  );

  always_comb begin
    alu_res = '0;
    case (funct3)
      F3_ADD:  alu_res = (opcode == OPC_OP && inst_i[30]) ? op1_i - op2_i : op1_i + op2_i;
      F3_SLL:  alu_res = op1_i << op2_i[4:0];
      F3_SLT:  alu_res = {31'b0, $signed(op1_i) < $signed(op2_i)};
      F3_SLTU: alu_res = {31'b0, op1_i < op2_i};
      F3_XOR:  alu_res = op1_i ^ op2_i;
      F3_SR:   alu_res = inst_i[30] ? $signed(op1_i) >>> op2_i[4:0] : op1_i >> op2_i[4:0];
      F3_OR:   alu_res = op1_i | op2_i;
      F3_AND:  alu_res = op1_i & op2_i;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      F3_BEQ:  br_taken = (op1_i == op2_i);
      F3_BNE:  br_taken = (op1_i != op2_i);
      F3_BLT:  br_taken = ($signed(op1_i) < $signed(op2_i));
      F3_BGE:  br_taken = ($signed(op1_i) >= $signed(op2_i));
      F3_BLTU: br_taken = (op1_i < op2_i);
      F3_BGEU: br_taken = (op1_i >= op2_i);
      default: br_taken = 1'b0;
    endcase
  end

`ifdef EX_MUL_EN
  logic signed [32:0] mul_a, mul_b;
  logic signed [65:0] mul_p;
  logic        [31:0] mul_res;
  assign mul_a   = $signed({(funct3 != F3_MULHU) & op1_i[31], op1_i});
  assign mul_b   = $signed({(funct3 == F3_MUL || funct3 == F3_MULH) & op2_i[31], op2_i});
  assign mul_p   = mul_a * mul_b;
  assign mul_res = (funct3 == F3_MUL) ? mul_p[31:0] : mul_p[63:32];
`endif

  always_comb begin
    rd_addr_o   = '0;
    rd_data_o   = '0;
    rd_wen_o    = 1'b0;
    jump_en_o   = 1'b0;
    jump_addr_o = '0;
    hold_o      = 1'b0;
    if (rst) begin
      if (div_done) begin
        rd_wen_o  = div_wen;
        rd_addr_o = div_rd;
        rd_data_o = div_res;
      end else if (div_busy) begin
        hold_o = 1'b1;
      end else if (inst_i != INST_NOP) begin
        case (opcode)
          OPC_OP: begin
            if (is_div) begin
              hold_o = 1'b1;
            end else if (is_muldiv) begin
`ifdef EX_MUL_EN
              rd_wen_o  = reg_wen_i;
              rd_addr_o = rd_addr_i;
              rd_data_o = mul_res;
`endif
            end else begin
              rd_wen_o  = reg_wen_i;
              rd_addr_o = rd_addr_i;
              rd_data_o = alu_res;
            end
          end
          OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
            rd_wen_o  = reg_wen_i;
            rd_addr_o = rd_addr_i;
            rd_data_o = (opcode == OPC_LUI)   ? imm_u :
                        (opcode == OPC_AUIPC) ? inst_addr_i + imm_u : alu_res;
          end
          OPC_JAL, OPC_JALR: begin
            rd_wen_o    = reg_wen_i;
            rd_addr_o   = rd_addr_i;
            rd_data_o   = inst_addr_i + 32'd4;
            jump_en_o   = 1'b1;
            jump_addr_o = (opcode == OPC_JAL) ? inst_addr_i + imm_j
                                              : (op1_i + imm_i) & 32'hFFFFFFFE;
          end
          OPC_BRANCH: begin
            jump_en_o   = br_taken;
            jump_addr_o = br_taken ? inst_addr_i + imm_b : '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
- Execute stage of the three-stage RV32 pipeline. It sits directly downstream of the ID/EX register and consumes the instruction word, PC, operands, rd address and write enable that register produces.
- Single-cycle RV32I ALU, branch and jump resolution, plus an iterative divider for DIV/DIVU/REM/REMU.
- Drives register-file writeback and the redirect to IF.
- Raises a hold request so the upstream pipeline registers freeze while a divide is in flight.

Parameters:
- DIV_BITS_PER_CYCLE, default 1. Quotient bits produced per BUSY cycle; legal values 1 or 2; BUSY lasts 32/DIV_BITS_PER_CYCLE cycles.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low (rst==0 resets on the clk edge)
- inst_i  in  32  instruction from ID/EX
- inst_addr_i  in  32  PC of inst_i
- op1_i  in  32  operand 1 (rs1 value)
- op2_i  in  32  operand 2 (rs2 value or immediate)
- rd_addr_i  in  5  destination register
- reg_wen_i  in  1  destination write enable from decode
- rd_addr_o  out  5  writeback register address
- rd_data_o  out  32  writeback data
- rd_wen_o  out  1  writeback enable
- jump_en_o  out  1  redirect IF; flush IF/ID and ID/EX
- jump_addr_o  out  32  redirect target
- hold_o  out  1  stall request; IF/ID and ID/EX keep their contents

Behaviour:
- Reset (rst==0 at an edge):
  - FSM goes to IDLE; divider registers clear.
  - hold_o, rd_wen_o and jump_en_o are 0; rd_addr_o, rd_data_o and jump_addr_o are 0.
  - A divide in flight is abandoned and its result is never written.
- Single-cycle ops (OP, OP-IMM, LUI, AUIPC, JAL, JALR, BRANCH):
  - Combinational, zero latency. rd_wen_o = reg_wen_i; rd_data_o = result; rd_addr_o = rd_addr_i.
  - JAL/JALR write PC+4.
  - Taken branch or jump: jump_en_o=1 in the same cycle. The JALR target has bit0 cleared.
  - Shifts use op2[4:0]. SLT is signed; SLTU is unsigned.
  - INST_NOP and unknown opcodes: all write and jump outputs are 0.
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE and inst_i is a DIV-family op: latch operands, signedness, rem/quot select and rd_addr_i; hold_o=1; rd_wen_o=0.
    - Divisor==0 or signed overflow (0x80000000 / -1): go to DONE.
    - Otherwise go to BUSY.
  - BUSY: hold_o=1, rd_wen_o=0. An unsigned restoring divide on magnitudes; count down from 32/DIV_BITS_PER_CYCLE. Go to DONE when count hits 0.
  - DONE: hold_o=0, rd_wen_o = latched reg_wen, rd_addr_o = latched rd, rd_data_o = sign-corrected quotient or remainder. Return to IDLE.
    - inst_i still shows the divide in this cycle and must NOT restart the FSM.
  - Latency with DIV_BITS_PER_CYCLE=1: 34 cycles occupancy (1 IDLE-accept + 32 BUSY + 1 DONE). Special cases take 2 cycles.
- Sign and special-case rules:
  - Quotient is negated when operand signs differ; remainder takes the dividend's sign.
  - Divide by 0: quotient 0xFFFFFFFF, remainder = dividend.
  - Overflow: quotient 0x80000000, remainder 0.
- A jump cannot coincide with a divide (single-issue). rd_addr 0 writes are passed through; the regfile ignores x0.

Optional Feature:
- Macro EX_MUL_EN.
- Defined: MUL/MULH/MULHSU/MULHU complete in a single cycle. The 33x33 signed product is selected low or high; there is no hold.
- Undefined: MUL-family encodings behave as NOP (rd_wen_o=0, no hold, no jump).

Decomposition:
- defines.v holds:
  - opcode, funct3 and funct7 constants
  - INST_NOP (32'h00000013)
  - FSM state encodings
  - divide special-case constants
- One sub-module: div_unit. It contains the FSM, iteration datapath and sign fix-up, and exposes start, busy and done handshakes. ex_mdu holds the ALU, branch logic and output muxing.

Test Plan:
- ADDI x5,x0,-1 (op1=0, op2=0xFFFFFFFF) -> same cycle: rd_wen_o=1, rd_addr_o=5, rd_data_o=0xFFFFFFFF, hold_o=0.
- BEQ, op1=op2=7, pc=0x80000010, imm=0x20 -> jump_en_o=1, jump_addr_o=0x80000030, rd_wen_o=0.
- DIV x3, op1=-7, op2=2 -> hold_o=1 for 33 cycles; DONE cycle: rd_data_o=0xFFFFFFFD (-3), rd_wen_o=1. REM with the same operands -> 0xFFFFFFFF (-1).
- DIVU op2=0, op1=0x1234 -> 2-cycle occupancy, quotient 0xFFFFFFFF. REM 0x80000000 / -1 -> 0.
- rst=0 asserted at BUSY cycle 10 -> next cycle hold_o=0, rd_wen_o=0. After release, ADD executes normally with no stale divide write.
- EX_MUL_EN defined: MULH 0x80000000 * 0x80000000 -> 0x40000000, no hold. Undefined: rd_wen_o=0.
